// File: rtl/imm_encode_if.sv
// Request/response bundle for the immediate encoder: request side carries the
// immediate and its format, response side carries the buffered encoding.
interface imm_encode_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] ImmExt;
   logic [1:0]  ImmSrc;
   logic        out_valid;
   logic        out_ready;
   logic [24:0] immediate;
   logic        out_err;
   logic [7:0]  err_count;

   modport master (
      output in_valid, ImmExt, ImmSrc, out_ready,
      input  in_ready, out_valid, immediate, out_err, err_count
   );

   modport slave (
      input  in_valid, ImmExt, ImmSrc, out_ready,
      output in_ready, out_valid, immediate, out_err, err_count
   );
endinterface

// File: rtl/imm_encode.sv
// Encodes a sign-extended immediate back into instruction bits [31:7] for
// I/B/U/J formats, flags unrepresentable values, and buffers results in a 2-deep FIFO.
module imm_encode (
   input logic         clk,
   input logic         rst_n,
   imm_encode_if.slave bus
);

   typedef struct packed {
      logic        err;
      logic [24:0] imm;
   } entry_t;

   logic [24:0] enc;
   logic        enc_err;
   logic        push;
   logic        pop;

   entry_t      mem_q [2];
   logic        rd_ptr_q;
   logic        wr_ptr_q;
   logic [1:0]  cnt_q;
   logic [7:0]  err_count_q;

   // enc holds instruction bits [31:7], so instruction bit k lands at enc[k-7].
   always_comb begin
      enc     = '0;
      enc_err = 1'b0;
      unique case (bus.ImmSrc)
         2'd0: begin
            enc[24:13] = bus.ImmExt[11:0];
            enc_err    = !((&bus.ImmExt[31:11]) || !(|bus.ImmExt[31:11]));
         end
         2'd1: begin
            enc[24]    = bus.ImmExt[12];
            enc[23:18] = bus.ImmExt[10:5];
            enc[4:1]   = bus.ImmExt[4:1];
            enc[0]     = bus.ImmExt[11];
            enc_err    = bus.ImmExt[0] ||
                         !((&bus.ImmExt[31:12]) || !(|bus.ImmExt[31:12]));
         end
         2'd2: begin
            enc[24:5] = bus.ImmExt[31:12];
            enc_err   = |bus.ImmExt[11:0];
         end
         2'd3: begin
            enc[24]    = bus.ImmExt[20];
            enc[23:14] = bus.ImmExt[10:1];
            enc[13]    = bus.ImmExt[11];
            enc[12:5]  = bus.ImmExt[19:12];
            enc_err    = bus.ImmExt[0] ||
                         !((&bus.ImmExt[31:20]) || !(|bus.ImmExt[31:20]));
         end
         default: ;
      endcase
   end

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0]    <= '0;
         mem_q[1]    <= '0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         cnt_q       <= 2'd0;
         err_count_q <= 8'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= '{err: enc_err, imm: enc};
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         if (push && !pop) begin
            cnt_q <= cnt_q + 2'd1;
         end else if (pop && !push) begin
            cnt_q <= cnt_q - 2'd1;
         end
         if (push && enc_err && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
         end
      end
   end

   // Ready depends only on occupancy, never on out_ready.
   assign bus.in_ready  = (cnt_q != 2'd2);
   assign bus.out_valid = (cnt_q != 2'd0);
   assign bus.immediate = bus.out_valid ? mem_q[rd_ptr_q].imm : '0;
   assign bus.out_err   = bus.out_valid ? mem_q[rd_ptr_q].err : 1'b0;
   assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_imm_encode.sv
// Randomised and directed bench for imm_encode against an arithmetic reference model.
module tb_imm_encode;

   logic clk;
   logic rst_n;
   imm_encode_if bus ();

   imm_encode dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [24:0] imm;
      logic        err;
      logic [31:0] ext;
      logic [1:0]  src;
   } exp_t;

   exp_t q [$];
   int   m_err;
   int   checks;
   int   errors;

   // Reference: placement by format plus range rules on the signed value.
   function automatic void ref_enc(input logic [1:0] src, input logic [31:0] ext,
                                   output logic [24:0] imm, output logic err);
      logic [31:0] w;
      longint      s;
      s = longint'($signed(ext));
      case (src)
         2'd0: begin
            w   = {ext[11:0], 20'b0};
            err = !(s >= -2048 && s <= 2047);
         end
         2'd1: begin
            w   = {ext[12], ext[10:5], 13'b0, ext[4:1], ext[11], 7'b0};
            err = ext[0] || !(s >= -4096 && s <= 4095);
         end
         2'd2: begin
            w   = {ext[31:12], 12'b0};
            err = (ext[11:0] != 12'd0);
         end
         default: begin
            w   = {ext[20], ext[10:1], ext[11], ext[19:12], 12'b0};
            err = ext[0] || !(s >= -1048576 && s <= 1048575);
         end
      endcase
      imm = w[31:7];
   endfunction

   // Standard decoder sign-extension, used for the round-trip property.
   function automatic logic [31:0] decode(input logic [1:0] src, input logic [24:0] imm);
      logic [31:0] i;
      i = {imm, 7'b0};
      case (src)
         2'd0:    return {{20{i[31]}}, i[31:20]};
         2'd1:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         2'd2:    return {i[31:12], 12'b0};
         default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      endcase
   endfunction

   task automatic tick();
      bit   push;
      bit   pop;
      exp_t e;
      exp_t d;
      push = bus.in_valid && (q.size() < 2);
      pop  = (q.size() > 0) && bus.out_ready;
      if (push) begin
         ref_enc(bus.ImmSrc, bus.ImmExt, e.imm, e.err);
         e.ext = bus.ImmExt;
         e.src = bus.ImmSrc;
      end
      @(posedge clk);
      if (pop) d = q.pop_front();
      if (push) begin
         q.push_back(e);
         if (e.err && m_err < 255) m_err++;
      end
      #1;
   endtask

   task automatic drive(input bit v, input logic [1:0] src, input logic [31:0] ext,
                        input bit ordy);
      bus.in_valid  = v;
      bus.ImmSrc    = src;
      bus.ImmExt    = ext;
      bus.out_ready = ordy;
   endtask

   task automatic do_reset();
      drive(0, 2'd0, 32'd0, 0);
      rst_n = 1'b0;
      q.delete();
      m_err = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.out_valid !== 1'b0) begin errors++;
         $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++;
         $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      checks++; if (bus.immediate !== 25'd0) begin errors++;
         $display("FAIL reset_immediate got %h want 0", bus.immediate); end
      checks++; if (bus.out_err !== 1'b0) begin errors++;
         $display("FAIL reset_out_err got %b want 0", bus.out_err); end
      checks++; if (bus.err_count !== 8'd0) begin errors++;
         $display("FAIL reset_err_count got %0d want 0", bus.err_count); end
   endtask

   task automatic test_vectors();
      logic [1:0]  vsrc [5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
      logic [31:0] vext [5] = '{32'hFFFFF800, 32'h00000FFE, 32'h00000003,
                                32'h12345001, 32'h000FFFFE};
      logic [31:0] vexp [5] = '{32'h80000000, 32'h7E000F80, 32'h00000100,
                                32'h12345000, 32'h7FFFF000};
      logic        verr [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [7:0]  vcnt [5] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd2};
      for (int k = 0; k < 5; k++) begin
         drive(1, vsrc[k], vext[k], 0);
         checks++; if (bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL vec%0d_pre_valid got %b want 0", k, bus.out_valid); end
         tick();
         drive(0, 2'd0, 32'd0, 0);
         checks++; if (bus.out_valid !== 1'b1) begin errors++;
            $display("FAIL vec%0d_valid got %b want 1", k, bus.out_valid); end
         checks++; if ({bus.immediate, 7'b0} !== vexp[k]) begin errors++;
            $display("FAIL vec%0d_imm got %h want %h", k, {bus.immediate, 7'b0}, vexp[k]); end
         checks++; if (bus.out_err !== verr[k]) begin errors++;
            $display("FAIL vec%0d_err got %b want %b", k, bus.out_err, verr[k]); end
         checks++; if (bus.err_count !== vcnt[k]) begin errors++;
            $display("FAIL vec%0d_cnt got %0d want %0d", k, bus.err_count, vcnt[k]); end
         drive(0, 2'd0, 32'd0, 1);
         tick();
         drive(0, 2'd0, 32'd0, 0);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a = 32'h00000011;
      logic [31:0] b = 32'h00000022;
      logic [31:0] c = 32'h00000033;
      drive(1, 2'd0, a, 0); tick();
      drive(1, 2'd0, b, 0); tick();
      checks++; if (bus.in_ready !== 1'b0) begin errors++;
         $display("FAIL b2b_full_ready got %b want 0", bus.in_ready); end
      drive(1, 2'd0, c, 0); tick();
      checks++; if (bus.in_ready !== 1'b0 || bus.immediate !== {a[11:0], 13'b0}) begin
         errors++;
         $display("FAIL b2b_held got ready %b imm %h want 0 %h", bus.in_ready,
                  bus.immediate, {a[11:0], 13'b0}); end
      drive(1, 2'd0, c, 1); tick();
      checks++; if (bus.immediate !== {b[11:0], 13'b0} || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second got imm %h ready %b want %h 1", bus.immediate,
                  bus.in_ready, {b[11:0], 13'b0}); end
      drive(1, 2'd0, c, 1); tick();
      checks++; if (bus.immediate !== {c[11:0], 13'b0} || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_third got imm %h valid %b want %h 1", bus.immediate,
                  bus.out_valid, {c[11:0], 13'b0}); end
      drive(0, 2'd0, 32'd0, 1); tick();
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++;
         $display("FAIL b2b_drain got valid %b ready %b want 0 1", bus.out_valid,
                  bus.in_ready); end
      drive(0, 2'd0, 32'd0, 0);
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic [31:0] ext;
      for (int i = 0; i < 600; i++) begin
         r = $urandom;
         case ($urandom_range(0, 4))
            0:       ext = $urandom;
            1:       ext = {{20{r[11]}}, r[11:0]};
            2:       ext = {{19{r[12]}}, r[12:1], 1'b0};
            3:       ext = {r[31:12], 12'b0};
            default: ext = {{11{r[20]}}, r[20:1], 1'b0};
         endcase
         drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), ext,
               $urandom_range(0, 2) != 0);
         checks++; if (bus.out_valid !== (q.size() != 0)) begin errors++;
            $display("FAIL rnd_valid cyc %0d got %b want %b", i, bus.out_valid, q.size() != 0);
         end
         checks++; if (bus.in_ready !== (q.size() < 2)) begin errors++;
            $display("FAIL rnd_ready cyc %0d got %b want %b", i, bus.in_ready, q.size() < 2);
         end
         checks++; if (bus.err_count !== 8'(m_err)) begin errors++;
            $display("FAIL rnd_cnt cyc %0d got %0d want %0d", i, bus.err_count, m_err); end
         if (q.size() != 0) begin
            checks++; if (bus.immediate !== q[0].imm || bus.out_err !== q[0].err) begin
               errors++;
               $display("FAIL rnd_head cyc %0d got %h/%b want %h/%b", i, bus.immediate,
                        bus.out_err, q[0].imm, q[0].err); end
            if (!q[0].err) begin
               checks++; if (decode(q[0].src, bus.immediate) !== q[0].ext) begin errors++;
                  $display("FAIL rnd_roundtrip cyc %0d got %h want %h", i,
                           decode(q[0].src, bus.immediate), q[0].ext); end
            end
         end
         tick();
      end
      drive(0, 2'd0, 32'd0, 0);
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(1, 2'd2, 32'h00000001, 1); tick();
      end
      drive(0, 2'd0, 32'd0, 1); tick();
      drive(1, 2'd0, 32'h00000044, 0); tick();
      drive(1, 2'd0, 32'h00000055, 0); tick();
      drive(0, 2'd0, 32'd0, 0);
      checks++; if (bus.err_count !== 8'd5 || bus.in_ready !== 1'b0) begin errors++;
         $display("FAIL mid_setup got cnt %0d ready %b want 5 0", bus.err_count,
                  bus.in_ready); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.err_count !== 8'd0) begin errors++;
         $display("FAIL mid_async got valid %b cnt %0d want 0 0", bus.out_valid,
                  bus.err_count); end
      checks++; if (bus.in_ready !== 1'b1 || bus.immediate !== 25'd0) begin errors++;
         $display("FAIL mid_async_ready got %b imm %h want 1 0", bus.in_ready,
                  bus.immediate); end
      q.delete();
      m_err = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1, 2'd0, 32'h00000005, 0); tick();
      drive(0, 2'd0, 32'd0, 0);
      checks++; if (bus.out_valid !== 1'b1 || bus.immediate !== 25'h0000A000) begin
         errors++;
         $display("FAIL mid_first got valid %b imm %h want 1 0000a000", bus.out_valid,
                  bus.immediate); end
      drive(0, 2'd0, 32'd0, 1); tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++;
         $display("FAIL mid_drain got %b want 0", bus.out_valid); end
      drive(1, 2'd2, 32'h00000001, 1);
      repeat (300) tick();
      drive(0, 2'd0, 32'd0, 1); tick();
      checks++; if (bus.err_count !== 8'd255) begin errors++;
         $display("FAIL sat_cnt got %0d want 255", bus.err_count); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_err  = 0;
      rst_n  = 1'b0;
      drive(0, 2'd0, 32'd0, 0);
      test_reset();
      test_vectors();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
